// File: rtl/uart_tx_if.sv
// Byte handshake between a stream producer and uart_tx.
// The producer holds tdata/tvalid until it sees tready high on a clock edge.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
// txd goes low one clock after acceptance; tready is low for the whole frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_if.slave        axis,
  output logic            txd,
  output logic            busy,
  input  logic [15:0]     prescale,
  input  logic            parity_en,
  input  logic            parity_odd,
  input  logic            stop2
);

  localparam int CW = 19;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state,     w_state;
  logic [DATA_WIDTH-1:0] r_data,      w_data;
  logic [CW-1:0]         r_bit_time,  w_bit_time;
  logic [CW-1:0]         r_cnt,       w_cnt;
  logic [IW-1:0]         r_idx,       w_idx;
  logic                  r_par_en,    w_par_en;
  logic                  r_par_bit,   w_par_bit;
  logic                  r_stop2,     w_stop2;
  logic                  r_stop_half, w_stop_half;
  logic                  r_txd,       w_txd;
  logic                  r_busy;
  logic                  r_tready;

  logic                  w_accept;
  logic                  w_cnt_done;
  logic [DATA_WIDTH-1:0] w_data_shift;

  assign w_accept     = r_tready & axis.s_axis_tvalid;
  assign w_cnt_done   = (r_cnt == (r_bit_time - CW'(1)));
  assign w_data_shift = r_data >> 1;

  assign txd                = r_txd;
  assign busy               = r_busy;
  assign axis.s_axis_tready = r_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_bit_time  <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_half <= 1'b0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_tready    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_data      <= w_data;
      r_bit_time  <= w_bit_time;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_par_en    <= w_par_en;
      r_par_bit   <= w_par_bit;
      r_stop2     <= w_stop2;
      r_stop_half <= w_stop_half;
      r_txd       <= w_txd;
      r_busy      <= (w_state != IDLE);
      r_tready    <= (w_state == IDLE);
    end
  end

  always_comb begin
    w_state     = r_state;
    w_data      = r_data;
    w_bit_time  = r_bit_time;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_par_en    = r_par_en;
    w_par_bit   = r_par_bit;
    w_stop2     = r_stop2;
    w_stop_half = r_stop_half;
    w_txd       = r_txd;

    case (r_state)
      IDLE: begin
        w_txd = 1'b1;
        if (w_accept) begin
          // Frame settings are captured here and held until the next acceptance.
          w_state     = START;
          w_data      = axis.s_axis_tdata;
          w_bit_time  = {((prescale == 16'd0) ? 16'd1 : prescale), 3'b000};
          w_par_en    = parity_en;
          w_par_bit   = (^axis.s_axis_tdata) ^ parity_odd;
          w_stop2     = stop2;
          w_cnt       = '0;
          w_idx       = '0;
          w_stop_half = 1'b0;
          w_txd       = 1'b0;
        end
      end
      START: begin
        if (w_cnt_done) begin
          w_state = DATA;
          w_cnt   = '0;
          w_txd   = r_data[0];
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_cnt_done) begin
          w_cnt = '0;
          if (r_idx == IW'(DATA_WIDTH - 1)) begin
            w_state = r_par_en ? PARITY : STOP;
            w_txd   = r_par_en ? r_par_bit : 1'b1;
          end else begin
            w_idx  = r_idx + IW'(1);
            w_data = w_data_shift;
            w_txd  = w_data_shift[0];
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      PARITY: begin
        if (w_cnt_done) begin
          w_state = STOP;
          w_cnt   = '0;
          w_txd   = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (w_cnt_done) begin
          w_cnt = '0;
          w_txd = 1'b1;
          // Two stop bits are run as two back-to-back bit periods.
          if (r_stop2 && !r_stop_half) begin
            w_stop_half = 1'b1;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_txd   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed sends push expected frames; a txd monitor decodes
// and times every frame cycle-by-cycle against the queued expectation.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;

  uart_tx_if #(.DATA_WIDTH(8)) axis_if ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .axis       (axis_if),
    .txd        (txd),
    .busy       (busy),
    .prescale   (prescale),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2)
  );

  typedef struct {
    logic [7:0] data;
    int         bt;
    bit         pe;
    bit         par;
    int         nstop;
    bit         b2b;
    bit         abort;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   frames_sent = 0;
  int   frames_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [7:0] d, input logic [15:0] presc, input bit pe,
                      input bit po, input bit s2, input int exp_bt, input bit exp_par,
                      input int exp_nstop, input bit b2b, input bit abort, input bit hold);
    exp_t e;
    int   n;
    axis_if.s_axis_tdata  = d;
    axis_if.s_axis_tvalid = 1'b1;
    prescale   = presc;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    n = 0;
    while (axis_if.s_axis_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("accept_timeout", 32'd1, 32'd0);
      axis_if.s_axis_tvalid = 1'b0;
      return;
    end
    e.data = d; e.bt = exp_bt; e.pe = pe; e.par = exp_par; e.nstop = exp_nstop;
    e.b2b = b2b; e.abort = abort; e.acc_cyc = cyc + 1;
    sb.push_back(e);
    frames_sent++;
    @(negedge clk);
    if (!hold) axis_if.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || axis_if.s_axis_tready !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: samples on negedge, checks every cycle of each frame.
  initial begin : monitor
    exp_t       e;
    int         total, k, bad_bits, bad_busy, idle_cnt;
    logic [7:0] rx;
    logic       par_s, expb;
    bit         stop_ok, aborted;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        idle_cnt = 0;
        continue;
      end
      if (txd !== 1'b0) begin
        idle_cnt++;
        continue;
      end
      if (sb.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
        idle_cnt = 0;
        continue;
      end
      e = sb.pop_front();
      frames_seen++;
      chk("start_latency", cyc, e.acc_cyc);
      if (e.b2b) chk("b2b_idle_gap", idle_cnt, 32'd1);
      total    = (1 + 8 + int'(e.pe) + e.nstop) * e.bt;
      bad_bits = 0; bad_busy = 0; aborted = 0; rx = '0; par_s = 1'b0; stop_ok = 1;
      for (int c = 0; c < total; c++) begin
        if (c > 0) @(negedge clk);
        if (rst === 1'b1) begin
          aborted = 1;
          break;
        end
        k = c / e.bt;
        if (k == 0)                expb = 1'b0;
        else if (k <= 8)           expb = e.data[k-1];
        else if (e.pe && k == 9)   expb = e.par;
        else                       expb = 1'b1;
        if (txd !== expb) bad_bits++;
        if (busy !== 1'b1) bad_busy++;
        if (c % e.bt == e.bt / 2) begin
          if (k >= 1 && k <= 8)    rx[k-1] = txd;
          else if (e.pe && k == 9) par_s = txd;
          else if (k >= 9 && txd !== 1'b1) stop_ok = 0;
        end
      end
      chk("frame_aborted", 32'(aborted), 32'(e.abort));
      if (aborted) begin
        idle_cnt = 0;
        continue;
      end
      chk("bit_timing", bad_bits, 32'd0);
      chk("busy_during_frame", bad_busy, 32'd0);
      chk("rx_byte", rx, e.data);
      if (e.pe) chk("rx_parity", par_s, e.par);
      chk("stop_bits", 32'(stop_ok), 32'd1);
      @(negedge clk);
      if (rst !== 1'b1) begin
        chk("idle_txd_after_frame", txd, 32'd1);
        chk("busy_after_frame", busy, 32'd0);
      end
      idle_cnt = 1;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1;
    axis_if.s_axis_tdata  = '0;
    axis_if.s_axis_tvalid = 1'b0;
    prescale = 16'd1; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;

    repeat (3) @(negedge clk);
    axis_if.s_axis_tvalid = 1'b1;
    #1;
    chk("reset_txd", txd, 32'd1);
    chk("reset_busy", busy, 32'd0);
    chk("reset_tready", axis_if.s_axis_tready, 32'd0);
    axis_if.s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("tready_before_first_edge", axis_if.s_axis_tready, 32'd0);
    @(posedge clk);
    #1 chk("tready_after_release", axis_if.s_axis_tready, 32'd1);
    @(negedge clk);

    // Basic frame, 0xA5, 8-clock bits.
    send(8'hA5, 16'd1, 0, 0, 0, 8, 0, 1, 0, 0, 0);
    wait_idle();
    @(negedge clk);

    // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0.
    send(8'h07, 16'd1, 1, 0, 0, 8, 1, 1, 0, 0, 0);
    wait_idle();
    @(negedge clk);
    send(8'h07, 16'd1, 1, 1, 0, 8, 0, 1, 0, 0, 0);
    wait_idle();
    @(negedge clk);

    // Back-to-back with tvalid held high.
    send(8'h00, 16'd1, 0, 0, 0, 8, 0, 1, 0, 0, 1);
    send(8'h01, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h02, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h04, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h08, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h10, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h20, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h40, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 1);
    send(8'h80, 16'd1, 0, 0, 0, 8, 0, 1, 1, 0, 0);
    wait_idle();
    @(negedge clk);

    // Config changed mid-frame must not affect the frame in flight.
    send(8'h96, 16'd1, 0, 0, 0, 8, 0, 1, 0, 0, 0);
    repeat (20) @(negedge clk);
    prescale = 16'd4;
    stop2    = 1'b1;
    wait_idle();
    @(negedge clk);
    send(8'h69, 16'd4, 0, 0, 1, 32, 0, 2, 0, 0, 0);
    wait_idle();
    @(negedge clk);

    // Reset during the data bits of 0x00.
    send(8'h00, 16'd1, 0, 0, 0, 8, 0, 1, 0, 1, 0);
    repeat (20) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midframe_reset_txd_async", txd, 32'd1);
    chk("midframe_reset_busy", busy, 32'd0);
    chk("midframe_reset_tready", axis_if.s_axis_tready, 32'd0);
    @(negedge clk);
    chk("midframe_reset_tready_held", axis_if.s_axis_tready, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midframe_tready_before_edge", axis_if.s_axis_tready, 32'd0);
    @(posedge clk);
    #1 chk("midframe_tready_after_release", axis_if.s_axis_tready, 32'd1);
    chk("midframe_busy_after_release", busy, 32'd0);
    @(negedge clk);
    send(8'h3C, 16'd1, 0, 0, 0, 8, 0, 1, 0, 0, 0);
    wait_idle();
    @(negedge clk);

    // Prescale 0 behaves as prescale 1.
    send(8'hFF, 16'd0, 0, 0, 0, 8, 0, 1, 0, 0, 0);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("frames_seen", frames_seen, frames_sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL provide port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port s_axis_tdata  input  DATA_WIDTH  byte to transmit.
REQ-005 SHALL provide port s_axis_tvalid  input  1  tdata valid.
REQ-006 SHALL provide port s_axis_tready  output  1  block accepts tdata this cycle.
REQ-007 SHALL provide port txd  output  1  serial line, idle high, LSB first.
REQ-008 SHALL provide port busy  output  1  frame in progress.
REQ-009 SHALL provide port prescale  input  16  bit time = prescale*8 clocks.
REQ-010 SHALL provide port parity_en  input  1  append parity bit after data.
REQ-011 SHALL provide port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-012 SHALL provide port stop2  input  1  1 = two stop bits, 0 = one stop bit.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive s_axis_tready as a register: 1 in IDLE, 0 in all other states.
REQ-015 SHALL accept a word on the rising edge where s_axis_tvalid and s_axis_tready are both 1. On that edge it latches tdata, prescale, parity_en, parity_odd and stop2, enters START, clears tready, and sets busy.
REQ-016 SHALL ignore changes to prescale, parity_en, parity_odd and stop2 after acceptance until the next acceptance.
REQ-017 SHALL treat a latched prescale of 0 as 1, so the minimum bit time is 8 clocks.
REQ-018 SHALL hold each bit on txd for exactly B = prescale*8 clocks, counted with a bit-time counter of at least 19 bits.
REQ-019 SHALL drive txd low in the cycle after acceptance (one-cycle latency), and hold it for B clocks.
REQ-020 SHALL in DATA shift out DATA_WIDTH bits LSB first, each for B clocks.
REQ-021 SHALL in PARITY (entered only if parity_en was latched) drive the XOR of the data bits, inverted when parity_odd is 1, for B clocks.
REQ-022 SHALL in STOP drive txd high for B clocks, or 2*B clocks when stop2 was latched.
REQ-023 SHALL return to IDLE on the edge ending the last stop clock. tready rises and busy falls on that same edge.
REQ-024 SHALL therefore allow back-to-back frames with exactly one idle-high cycle between the end of the stop bit(s) and the next start bit.
REQ-025 SHALL give total frame occupancy of (1+DATA_WIDTH+P+S)*B clocks, where P = parity_en and S = 1+stop2.
REQ-026 SHALL keep txd registered and glitch-free, with no combinational path from any input to txd.
REQ-027 SHALL hold txd high and busy low whenever in IDLE, regardless of tvalid.

Reset
REQ-028 SHALL while rst is high force state IDLE, txd=1, busy=0, s_axis_tready=0, and clear all counters and the data shift register, asynchronously.
REQ-029 SHALL set s_axis_tready to 1 on the first rising clk edge after rst deasserts.
REQ-030 SHALL on reset mid-frame immediately drive txd high and discard the partial frame. No word is pending after reset.

Verification
REQ-031 Bench SHALL cover basic frame: prescale=1, parity_en=0, stop2=0, send 0xA5.
- txd = 0,1,0,1,0,0,1,0,1,1, each bit for 8 clocks.
- Start bit begins 1 cycle after the handshake.
- busy is high for 80 clocks.
REQ-032 Bench SHALL cover parity: prescale=1, parity_en=1.
- Even parity, send 0x07: parity bit = 1.
- Odd parity, send 0x07: parity bit = 0.
- Frame lasts 88 clocks.
REQ-033 Bench SHALL cover back-to-back transfer: tvalid held high for 0x00,0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80.
- Each next start bit follows 1 idle clock.
- Loopback into uart_rx (prescale=1) receives all 9 bytes in order, with no frame_error or overrun_error.
REQ-034 Bench SHALL cover configuration latching: change prescale 1->4 and set stop2=1 mid-frame.
- The current frame keeps 8-clock bits and one stop bit.
- The next frame uses 32-clock bits and a 64-clock stop period.
REQ-035 Bench SHALL cover reset mid-frame: assert rst during the data bits of 0x00.
- txd goes to 1 without waiting for a clk edge.
- busy=0 and tready=0 during reset.
- tready=1 one clock after release.
- The next sent byte 0x3C is received correctly by uart_rx.
REQ-036 Bench SHALL cover prescale=0: send 0xFF.
- Each bit lasts 8 clocks, identical to prescale=1.
